// File: rtl/nlf_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : nlf_channel_scheduler
// Description : Round-robin sharing of one pipelined nonlinear-function
//               evaluator between N_CH channels, with in-order tag return.
// Revision    : 1.0 - initial release
// ============================================================================
module nlf_channel_scheduler #(
    parameter int N_CH    = 4,
    parameter int IN_W    = 11,
    parameter int OUT_W   = 14,
    parameter int MAX_OUT = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_CH-1:0]        req_valid,
    input  logic [N_CH*IN_W-1:0]   req_data,
    output logic [N_CH-1:0]        req_ready,
    output logic                   fn_ce_in,
    output logic [IN_W-1:0]        fn_sig_in,
    input  logic                   fn_ce_out,
    input  logic [OUT_W-1:0]       fn_sig_out,
    output logic [N_CH-1:0]        resp_valid,
    output logic [N_CH*OUT_W-1:0]  resp_data,
    output logic                   busy,
    output logic                   err_orphan
);

    localparam int c_ptr_w = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_cnt_w = $clog2(MAX_OUT + 1);
    localparam int c_q_w   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MAX_OUT);
    localparam logic [c_q_w-1:0]   c_q_last  = c_q_w'(MAX_OUT - 1);
    localparam logic [c_ptr_w-1:0] c_ch_last = c_ptr_w'(N_CH - 1);
    localparam logic [c_ptr_w:0]   c_n_ch    = (c_ptr_w + 1)'(N_CH);

    logic [c_ptr_w-1:0] r_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] r_tag [MAX_OUT];
    logic [c_q_w-1:0]   r_wr;
    logic [c_q_w-1:0]   r_rd;
    logic               r_fn_ce_in;
    logic [IN_W-1:0]    r_fn_sig_in;
    logic [N_CH-1:0]    r_resp_valid;
    logic [OUT_W-1:0]   r_resp_data [N_CH];
    logic               r_busy;
    logic               r_err;

    logic               w_found;
    logic [c_ptr_w-1:0] w_sel;
    logic [c_ptr_w:0]   w_sum;
    logic               w_pop;
    logic               w_room;
    logic               w_push;
    logic [N_CH-1:0]    w_grant;
    logic [c_cnt_w-1:0] w_count_nxt;
    logic [c_ptr_w-1:0] w_tag_out;

    // Search from the RR pointer, wrapping modulo N_CH; first valid wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_sum = {1'b0, r_ptr} + (c_ptr_w + 1)'(i);
            if (w_sum >= c_n_ch) begin
                w_sum = w_sum - c_n_ch;
            end
            if (!w_found && req_valid[w_sum[c_ptr_w-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[c_ptr_w-1:0];
            end
        end
    end

    // A full queue may still accept a push when a result pops the same cycle.
    assign w_pop     = fn_ce_out && (r_count != '0);
    assign w_room    = (r_count != c_max_cnt) || fn_ce_out;
    assign w_push    = w_found && w_room;
    assign w_tag_out = r_tag[r_rd];

    always_comb begin
        w_grant = '0;
        if (w_push) begin
            w_grant[w_sel] = 1'b1;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr        <= '0;
            r_count      <= '0;
            r_wr         <= '0;
            r_rd         <= '0;
            r_fn_ce_in   <= 1'b0;
            r_fn_sig_in  <= '0;
            r_resp_valid <= '0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            for (int q = 0; q < MAX_OUT; q++) begin
                r_tag[q] <= '0;
            end
            for (int k = 0; k < N_CH; k++) begin
                r_resp_data[k] <= '0;
            end
        end else begin
            r_fn_ce_in <= w_push;
            if (w_push) begin
                r_fn_sig_in <= req_data[w_sel*IN_W +: IN_W];
                r_ptr       <= (w_sel == c_ch_last) ? '0 : w_sel + 1'b1;
                r_tag[r_wr] <= w_sel;
                r_wr        <= (r_wr == c_q_last) ? '0 : r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= (r_rd == c_q_last) ? '0 : r_rd + 1'b1;
            end
            r_count <= w_count_nxt;
            r_busy  <= (w_count_nxt != '0);
            if (fn_ce_out && (r_count == '0)) begin
                r_err <= 1'b1;
            end
            r_resp_valid <= '0;
            for (int k = 0; k < N_CH; k++) begin
                if (w_pop && (w_tag_out == c_ptr_w'(k))) begin
                    r_resp_valid[k] <= 1'b1;
                    r_resp_data[k]  <= fn_sig_out;
                end
            end
        end
    end

    // Grant is combinational, so it is masked directly while reset is held.
    assign req_ready  = w_grant & {N_CH{reset_n}};
    assign fn_ce_in   = r_fn_ce_in;
    assign fn_sig_in  = r_fn_sig_in;
    assign resp_valid = r_resp_valid;
    assign busy       = r_busy;
    assign err_orphan = r_err;

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_resp
            assign resp_data[g*OUT_W +: OUT_W] = r_resp_data[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/nlf_channel_scheduler.md
Name: nlf_channel_scheduler

Overview:
Time-multiplexes one shared pipelined nonlinear-function evaluator (11-bit in, 14-bit out, clock-enable handshake) between N_CH requesting control channels. Round-robin arbitration issues at most one sample per cycle into the evaluator. Issued channel indices are tracked in a tag queue, and each result is routed back to the channel that requested it. It sits between the per-channel controller datapaths and a single evaluator instance, so each channel does not need its own copy.

Parameters:
N_CH, 4, number of requesting channels (2..8)
IN_W, 11, evaluator input width (signed two's complement)
OUT_W, 14, evaluator output width
MAX_OUT, 4, maximum outstanding samples in evaluator; tag queue depth (must be >= evaluator latency)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  N_CH  per-channel sample available
req_data  in  N_CH*IN_W  per-channel sample; channel k at bits [k*IN_W +: IN_W]
req_ready  out  N_CH  one-hot grant; transfer on req_valid[k] & req_ready[k]
fn_ce_in  out  1  evaluator clock-enable/strobe in
fn_sig_in  out  IN_W  evaluator sample in
fn_ce_out  in  1  evaluator result strobe
fn_sig_out  in  OUT_W  evaluator result
resp_valid  out  N_CH  one-cycle pulse, result ready for channel k
resp_data  out  N_CH*OUT_W  per-channel held result; channel k at [k*OUT_W +: OUT_W]
busy  out  1  outstanding count != 0
err_orphan  out  1  sticky: fn_ce_out seen with empty tag queue

Behaviour:
- Reset (async assert, sync release) clears these to 0: req_ready, fn_ce_in, fn_sig_in, resp_valid, resp_data, busy, err_orphan, the RR pointer, the outstanding count and the tag queue.
- Arbitration is combinational within the cycle. Search starts at RR pointer p and proceeds p, p+1, ... mod N_CH. The first k with req_valid[k] gets req_ready[k]=1. At most one bit of req_ready is set.
- Grant is allowed only when the queue is not full: outstanding < MAX_OUT, or outstanding == MAX_OUT with fn_ce_out=1 in the same cycle (simultaneous pop frees a slot). Otherwise req_ready=0.
- On a transfer to channel k at edge t:
  - fn_ce_in=1 and fn_sig_in=req_data[k] are registered and visible in cycle t+1.
  - k is pushed into the tag queue.
  - p <= (k+1) mod N_CH.
- Without a grant: fn_ce_in=0, fn_sig_in holds its last value, and p is unchanged.
- Result return on fn_ce_out=1 at edge u:
  - If the queue is non-empty, pop tag j. At u+1, resp_data[j] <= fn_sig_out and resp_valid[j]=1 for one cycle. Other channels' resp_data are held.
  - If the queue is empty, set err_orphan (sticky until reset) and discard the result. No resp_valid pulse.
- Simultaneous push and pop in one cycle: the count is unchanged and FIFO order is preserved. Results map to channels strictly in issue order, since the evaluator is in-order.
- Outstanding count range is 0..MAX_OUT. It never exceeds MAX_OUT and never underflows.
- busy = registered (count != 0).
- Latency: req transfer → fn_ce_in is 1 cycle. fn_ce_out → resp_valid is 1 cycle. End-to-end is evaluator latency L + 2 cycles.
- Throughput: 1 sample/cycle aggregate when MAX_OUT >= L. Each channel waits at most N_CH-1 grants while continuously valid (no starvation).
- Reset mid-operation: in-flight tags are discarded. Results arriving after reset release with an empty queue set err_orphan. The bench must hold the evaluator in reset together with this block.

Test Plan:
- Single request: N_CH=4, evaluator model L=3 with out = sign-extended in×2. req_valid=0010, req_data[1]=11'd100 → req_ready=0010; fn_ce_in at t+1 with fn_sig_in=100; resp_valid=0010 at t+5; resp_data[1]=200; other channels stay 0.
- Round robin: all four req_valid held high for 8 cycles → grant order ch0,1,2,3,0,1,2,3; fn_ce_in high 8 consecutive cycles; each channel's resp_valid pulses twice, in the same order.
- Backpressure: model L=6, MAX_OUT=4, all channels valid → exactly 4 grants, then req_ready=0 until first fn_ce_out; afterwards grants resume 1 per pop with count never >4; busy=1 throughout.
- Simultaneous push/pop at full: count=4 and fn_ce_out=1 in the same cycle as a valid request → grant issued, count stays 4, tag order correct. Checked by distinct data per channel: ch0=-5 → -10, ch2=1023 → 2046.
- Orphan: with no requests pending, force fn_ce_out=1 for one cycle → err_orphan=1 and stays 1; no resp_valid pulse.
- Async reset: assert reset_n=0 mid-burst (between clock edges) → all outputs 0 immediately; after release, first grant goes to ch0 (pointer reset).
